// File: rtl/cvxif_copro_pkg.sv
// Shared types for the CV-X-IF reference coprocessor:
// custom-3 decode constants, op/state enums and queue entry metadata.
package cvxif_copro_pkg;

    localparam logic [6:0] OPC_CUSTOM3 = 7'b1111011;
    localparam logic [6:0] F7_BASE     = 7'b0000000;
    localparam logic [2:0] F3_ADD      = 3'b000;
    localparam logic [2:0] F3_XOR      = 3'b001;
    localparam logic [2:0] F3_SLL      = 3'b010;
    localparam logic [2:0] F3_NOP      = 3'b011;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_XOR,
        OP_SLL,
        OP_NOP
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [4:0] rd;
        logic       committed;
        logic       killed;
    } entry_meta_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

    function automatic logic needs_rs(input op_e op);
        return op != OP_NOP;
    endfunction

endpackage

// File: rtl/cvxif_copro_queue.sv
// In-order circular buffer of offloaded instructions.
// Entries are marked committed/killed by ID and popped from the head.
module cvxif_copro_queue
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ID_WIDTH = 2,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [ID_WIDTH-1:0] push_id_i,
    input  entry_meta_t         push_meta_i,
    input  logic [XLEN-1:0]     push_rs1_i,
    input  logic [XLEN-1:0]     push_rs2_i,
    output logic                full_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    input  logic                pop_i,
    output logic                head_valid_o,
    output logic [ID_WIDTH-1:0] head_id_o,
    output entry_meta_t         head_meta_o,
    output logic [XLEN-1:0]     head_rs1_o,
    output logic [XLEN-1:0]     head_rs2_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]         wr_q;
    logic [PW:0]         rd_q;
    logic [DEPTH-1:0]    valid_q;
    entry_meta_t         meta_q [DEPTH];
    logic [ID_WIDTH-1:0] id_q   [DEPTH];
    logic [XLEN-1:0]     rs1_q  [DEPTH];
    logic [XLEN-1:0]     rs2_q  [DEPTH];
    logic [PW-1:0]       wr_idx;
    logic [PW-1:0]       rd_idx;
    logic                dup_id;

    assign wr_idx       = wr_q[PW-1:0];
    assign rd_idx       = rd_q[PW-1:0];
    assign full_o       = (wr_q[PW] != rd_q[PW]) && (wr_idx == rd_idx);
    assign head_valid_o = valid_q[rd_idx];
    assign head_id_o    = id_q[rd_idx];
    assign head_meta_o  = meta_q[rd_idx];
    assign head_rs1_o   = rs1_q[rd_idx];
    assign head_rs2_o   = rs2_q[rd_idx];

    // A new entry is written after the commit scan, so a same-cycle
    // commit of its ID cannot mark it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                meta_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && valid_q[i] &&
                    id_q[i] == commit_id_i) begin
                    meta_q[i].committed <= 1'b1;
                    if (commit_kill_i) begin
                        meta_q[i].killed <= 1'b1;
                    end
                end
            end
            if (pop_i) begin
                valid_q[rd_idx] <= 1'b0;
                rd_q            <= rd_q + 1'b1;
            end
            if (push_i) begin
                valid_q[wr_idx] <= 1'b1;
                meta_q[wr_idx]  <= push_meta_i;
                wr_q            <= wr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            id_q[wr_idx]  <= push_id_i;
            rs1_q[wr_idx] <= push_rs1_i;
            rs2_q[wr_idx] <= push_rs2_i;
        end
    end

    always_comb begin
        dup_id = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && id_q[i] == push_id_i &&
                !(pop_i && PW'(i) == rd_idx)) begin
                dup_id = 1'b1;
            end
        end
    end

    a_no_dup_id: assert property (
        @(posedge clk_i) disable iff (!rst_ni) push_i |-> !dup_id
    );

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: custom-3 decoder, in-order
// execution FSM with fixed latency and a held result handshake.
module cvxif_copro_responder
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ID_WIDTH = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned EXEC_LAT = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                x_issue_valid_i,
    output logic                x_issue_ready_o,
    input  logic [31:0]         x_issue_instr_i,
    input  logic [ID_WIDTH-1:0] x_issue_id_i,
    input  logic [XLEN-1:0]     x_issue_rs1_i,
    input  logic [XLEN-1:0]     x_issue_rs2_i,
    input  logic [1:0]          x_issue_rs_valid_i,
    output logic                x_issue_accept_o,
    output logic                x_issue_writeback_o,
    input  logic                x_commit_valid_i,
    input  logic [ID_WIDTH-1:0] x_commit_id_i,
    input  logic                x_commit_kill_i,
    output logic                x_result_valid_o,
    input  logic                x_result_ready_i,
    output logic [ID_WIDTH-1:0] x_result_id_o,
    output logic [XLEN-1:0]     x_result_data_o,
    output logic [4:0]          x_result_rd_o,
    output logic                x_result_we_o
);

    localparam int unsigned CW = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

    logic                dec_legal;
    op_e                 dec_op;
    logic [2:0]          f3;
    logic                accept_w;
    logic                push;
    logic                pop;
    logic                q_full;
    entry_meta_t         push_meta;
    logic                head_valid;
    logic [ID_WIDTH-1:0] head_id;
    entry_meta_t         head_meta;
    logic [XLEN-1:0]     head_rs1;
    logic [XLEN-1:0]     head_rs2;
    logic [XLEN-1:0]     alu;
    logic                unused_ok;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ID_WIDTH-1:0] res_id_q, res_id_d;
    logic [XLEN-1:0]     res_data_q, res_data_d;
    logic [4:0]          res_rd_q, res_rd_d;
    logic                res_we_q, res_we_d;

    assign f3        = x_issue_instr_i[14:12];
    assign unused_ok = ^x_issue_instr_i[24:15];

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_NOP;
        if (x_issue_instr_i[6:0] == OPC_CUSTOM3 &&
            x_issue_instr_i[31:25] == F7_BASE) begin
            unique case (1'b1)
                f3 == F3_ADD: begin dec_legal = 1'b1; dec_op = OP_ADD; end
                f3 == F3_XOR: begin dec_legal = 1'b1; dec_op = OP_XOR; end
                f3 == F3_SLL: begin dec_legal = 1'b1; dec_op = OP_SLL; end
                f3 == F3_NOP: begin dec_legal = 1'b1; dec_op = OP_NOP; end
                default: ;
            endcase
        end
    end

    assign accept_w = dec_legal &&
                      (!needs_rs(dec_op) || (&x_issue_rs_valid_i));
    assign x_issue_ready_o     = !q_full;
    assign push                = x_issue_valid_i && x_issue_ready_o && accept_w;
    assign x_issue_accept_o    = push;
    assign x_issue_writeback_o = push && (dec_op != OP_NOP);

    assign push_meta = '{op: dec_op, rd: x_issue_instr_i[11:7],
                         committed: 1'b0, killed: 1'b0};

    cvxif_copro_queue #(
        .XLEN     (XLEN),
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (DEPTH)
    ) u_queue (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .push_i         (push),
        .push_id_i      (x_issue_id_i),
        .push_meta_i    (push_meta),
        .push_rs1_i     (x_issue_rs1_i),
        .push_rs2_i     (x_issue_rs2_i),
        .full_o         (q_full),
        .commit_valid_i (x_commit_valid_i),
        .commit_id_i    (x_commit_id_i),
        .commit_kill_i  (x_commit_kill_i),
        .pop_i          (pop),
        .head_valid_o   (head_valid),
        .head_id_o      (head_id),
        .head_meta_o    (head_meta),
        .head_rs1_o     (head_rs1),
        .head_rs2_o     (head_rs2)
    );

    always_comb begin
        unique case (head_meta.op)
            OP_ADD:  alu = head_rs1 + head_rs2;
            OP_XOR:  alu = head_rs1 ^ head_rs2;
            OP_SLL:  alu = head_rs1 << head_rs2[4:0];
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        res_id_d   = res_id_q;
        res_data_d = res_data_q;
        res_rd_d   = res_rd_q;
        res_we_d   = res_we_q;
        pop        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (head_valid && head_meta.committed) begin
                    if (head_meta.killed || head_meta.op == OP_NOP) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                        cnt_d   = CW'(EXEC_LAT - 1);
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d    = S_RESP;
                    res_id_d   = head_id;
                    res_data_d = alu;
                    res_rd_d   = head_meta.rd;
                    res_we_d   = head_meta.op != OP_NOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (x_result_ready_i) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            res_id_q   <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
            res_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            res_id_q   <= res_id_d;
            res_data_q <= res_data_d;
            res_rd_q   <= res_rd_d;
            res_we_q   <= res_we_d;
        end
    end

    assign x_result_valid_o = (state_q == S_RESP);
    assign x_result_id_o    = res_id_q;
    assign x_result_data_o  = res_data_q;
    assign x_result_rd_o    = res_rd_q;
    assign x_result_we_o    = res_we_q;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Randomized bench for cvxif_copro_responder against a queue-based
// reference model of the offload protocol.
module tb_cvxif_copro_responder;

    localparam int EXEC_LAT = 2;
    localparam int DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [31:0] issue_instr = '0;
    logic [1:0]  issue_id = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [1:0]  rs_valid = '0;
    logic        commit_valid = 1'b0;
    logic [1:0]  commit_id = '0;
    logic        commit_kill = 1'b0;
    logic        result_ready = 1'b0;
    logic        issue_ready, issue_accept, issue_wb;
    logic        result_valid, result_we;
    logic [1:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]  id;
        logic [4:0]  rd;
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        bit          committed;
        bit          killed;
    } ment_t;

    typedef struct {
        bit          got;
        logic [1:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } res_t;

    ment_t mq[$];
    res_t  obs_q[$];
    res_t  exp_q[$];

    always #5 clk = ~clk;

    cvxif_copro_responder #(
        .XLEN(32), .ID_WIDTH(2), .DEPTH(DEPTH), .EXEC_LAT(EXEC_LAT)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .x_issue_valid_i     (issue_valid),
        .x_issue_ready_o     (issue_ready),
        .x_issue_instr_i     (issue_instr),
        .x_issue_id_i        (issue_id),
        .x_issue_rs1_i       (rs1),
        .x_issue_rs2_i       (rs2),
        .x_issue_rs_valid_i  (rs_valid),
        .x_issue_accept_o    (issue_accept),
        .x_issue_writeback_o (issue_wb),
        .x_commit_valid_i    (commit_valid),
        .x_commit_id_i       (commit_id),
        .x_commit_kill_i     (commit_kill),
        .x_result_valid_o    (result_valid),
        .x_result_ready_i    (result_ready),
        .x_result_id_o       (result_id),
        .x_result_data_o     (result_data),
        .x_result_rd_o       (result_rd),
        .x_result_we_o       (result_we)
    );

    function automatic logic [31:0] mk_instr(input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] opc, input logic [6:0] f7);
        return {f7, 5'($urandom), 5'($urandom), f3, rd, opc};
    endfunction

    // op: 0 add, 1 xor, 2 sll, 3 nop, -1 illegal
    function automatic void ref_decode(input logic [31:0] ins,
        input logic [1:0] rsv, output bit acc, output bit wb, output int op);
        op = -1;
        if (ins[6:0] == 7'h7B && ins[31:25] == 7'd0 && ins[14:12] <= 3'd3)
            op = int'(ins[14:12]);
        acc = (op == 3) || (op >= 0 && rsv == 2'b11);
        wb  = acc && op != 3;
    endfunction

    function automatic logic [31:0] ref_alu(input int op,
        input logic [31:0] a, input logic [31:0] b);
        case (op)
            0: return a + b;
            1: return a ^ b;
            2: return a << b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic do_issue(input logic [31:0] ins, input logic [1:0] id,
        input logic [31:0] a, input logic [31:0] b, input logic [1:0] rsv,
        output logic acc, output logic wb);
        bit racc, rwb;
        int op;
        @(negedge clk);
        issue_valid = 1'b1; issue_instr = ins; issue_id = id;
        rs1 = a; rs2 = b; rs_valid = rsv;
        #1;
        acc = issue_accept;
        wb  = issue_wb;
        @(posedge clk);
        #1 issue_valid = 1'b0;
        ref_decode(ins, rsv, racc, rwb, op);
        if (racc)
            mq.push_back('{id: id, rd: ins[11:7], op: op, a: a, b: b,
                           committed: 1'b0, killed: 1'b0});
    endtask

    task automatic do_commit(input logic [1:0] id, input logic kill);
        @(negedge clk);
        commit_valid = 1'b1; commit_id = id; commit_kill = kill;
        @(posedge clk);
        #1 commit_valid = 1'b0; commit_kill = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].id == id) begin
                mq[i].committed = 1'b1;
                if (kill) mq[i].killed = 1'b1;
            end
        end
    endtask

    function automatic void build_expected();
        ment_t e;
        exp_q.delete();
        while (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.committed && !e.killed && e.op != 3)
                exp_q.push_back('{got: 1'b1, id: e.id,
                    data: ref_alu(e.op, e.a, e.b), rd: e.rd, we: 1'b1});
        end
    endfunction

    task automatic collect(input int n);
        bit dead = 1'b0;
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            res_t r;
            r = '{got: 1'b0, id: '0, data: '0, rd: '0, we: 1'b0};
            if (!dead) begin
                for (int c = 0; c < 40 && !r.got; c++) begin
                    @(posedge clk); #1;
                    if (result_valid) begin
                        r = '{got: 1'b1, id: result_id, data: result_data,
                              rd: result_rd, we: result_we};
                    end
                end
                if (!r.got) dead = 1'b1;
                else begin
                    result_ready = 1'b1;
                    @(posedge clk);
                    #1 result_ready = 1'b0;
                end
            end
            obs_q.push_back(r);
        end
    endtask

    task automatic idle_watch(input int n, output bit seen);
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (result_valid) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({issue_ready, result_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_hs: ready/valid %b want 10",
                     {issue_ready, result_valid});
        end
        vectors++;
        if ({result_id, result_data, result_rd, result_we} !== '0) begin
            miscompares++;
            $display("FAIL reset_res: id %0d data %h rd %0d we %b want 0",
                     result_id, result_data, result_rd, result_we);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({issue_ready, result_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_after: ready/valid %b want 10",
                     {issue_ready, result_valid});
        end
    endtask

    task automatic test_add();
        logic acc, wb;
        int cyc = 0;
        do_issue(mk_instr(3'b000, 5'd5, 7'h7B, 7'd0), 2'd1, 32'd3, 32'd4,
                 2'b11, acc, wb);
        vectors++;
        if ({acc, wb} !== 2'b11) begin
            miscompares++;
            $display("FAIL add_accept: acc/wb %b want 11", {acc, wb});
        end
        do_commit(2'd1, 1'b0);
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (result_valid) break;
        end
        vectors++;
        if (cyc != EXEC_LAT + 1) begin
            miscompares++;
            $display("FAIL add_latency: %0d cycles want %0d", cyc, EXEC_LAT + 1);
        end
        vectors++;
        if ({result_valid, result_id, result_rd, result_we, result_data} !==
            {1'b1, 2'd1, 5'd5, 1'b1, 32'h7}) begin
            miscompares++;
            $display("FAIL add_result: v%b id%0d rd%0d we%b data %h want id1 rd5 we1 data 7",
                     result_valid, result_id, result_rd, result_we, result_data);
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
        vectors++;
        if (result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL add_drop: valid %b want 0", result_valid);
        end
        mq.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reject();
        logic [31:0] ins [5];
        logic [1:0]  rsv [5];
        logic acc, wb;
        bit racc, rwb, seen;
        int op;
        ins[0] = mk_instr(3'b000, 5'd1, 7'h33, 7'd0); rsv[0] = 2'b11;
        ins[1] = mk_instr(3'b000, 5'd2, 7'h7B, 7'h20); rsv[1] = 2'b11;
        ins[2] = mk_instr(3'b100, 5'd3, 7'h7B, 7'd0); rsv[2] = 2'b11;
        ins[3] = mk_instr(3'b000, 5'd4, 7'h7B, 7'd0); rsv[3] = 2'b01;
        ins[4] = mk_instr(3'b010, 5'd6, 7'h7B, 7'd0); rsv[4] = 2'b10;
        for (int i = 0; i < 5; i++) begin
            do_issue(ins[i], 2'(i), $urandom, $urandom, rsv[i], acc, wb);
            ref_decode(ins[i], rsv[i], racc, rwb, op);
            vectors++;
            if ({acc, wb} !== {racc, rwb}) begin
                miscompares++;
                $display("FAIL reject%0d: acc/wb %b want %b", i, {acc, wb},
                         {racc, rwb});
            end
        end
        for (int i = 0; i < 4; i++) do_commit(2'(i), 1'b0);
        idle_watch(12, seen);
        vectors++;
        if (seen || issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reject_noresult: seen %b ready %b want 0 1",
                     seen, issue_ready);
        end
        mq.delete();
    endtask

    task automatic test_order();
        logic acc, wb;
        bit seen;
        do_issue(mk_instr(3'b001, 5'($urandom), 7'h7B, 7'd0), 2'd0,
                 $urandom, $urandom, 2'b11, acc, wb);
        do_issue(mk_instr(3'b010, 5'd9, 7'h7B, 7'd0), 2'd1,
                 32'd1, 32'h24, 2'b11, acc, wb);
        do_commit(2'd1, 1'b0);
        idle_watch(8, seen);
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL order_wait: result seen %b want 0", seen);
        end
        do_commit(2'd0, 1'b0);
        build_expected();
        collect(exp_q.size());
        vectors++;
        if (exp_q.size() != 2 || exp_q[1].data !== 32'h10) begin
            miscompares++;
            $display("FAIL order_model: %0d results want 2", exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if ({obs_q[i].got, obs_q[i].id, obs_q[i].rd, obs_q[i].we, obs_q[i].data} !==
                {1'b1, exp_q[i].id, exp_q[i].rd, exp_q[i].we, exp_q[i].data}) begin
                miscompares++;
                $display("FAIL order_res%0d: got v%b id%0d rd%0d we%b data %h, want id%0d rd%0d data %h",
                         i, obs_q[i].got, obs_q[i].id, obs_q[i].rd, obs_q[i].we,
                         obs_q[i].data, exp_q[i].id, exp_q[i].rd, exp_q[i].data);
            end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_kill();
        logic acc, wb;
        bit seen;
        logic [31:0] ins;
        do_issue(mk_instr(3'b000, 5'd7, 7'h7B, 7'd0), 2'd2,
                 $urandom, $urandom, 2'b11, acc, wb);
        do_issue(mk_instr(3'b000, 5'd8, 7'h7B, 7'd0), 2'd3,
                 $urandom, $urandom, 2'b11, acc, wb);
        do_commit(2'd2, 1'b1);
        do_commit(2'd3, 1'b0);
        build_expected();
        collect(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if ({obs_q[i].got, obs_q[i].id, obs_q[i].rd, obs_q[i].data} !==
                {1'b1, exp_q[i].id, exp_q[i].rd, exp_q[i].data}) begin
                miscompares++;
                $display("FAIL kill_res%0d: got v%b id%0d rd%0d data %h, want id%0d rd%0d data %h",
                         i, obs_q[i].got, obs_q[i].id, obs_q[i].rd, obs_q[i].data,
                         exp_q[i].id, exp_q[i].rd, exp_q[i].data);
            end
        end
        // commit in the issue cycle must not reach the new entry
        ins = mk_instr(3'b001, 5'd11, 7'h7B, 7'd0);
        @(negedge clk);
        issue_valid = 1'b1; issue_instr = ins; issue_id = 2'd1;
        rs1 = $urandom; rs2 = $urandom; rs_valid = 2'b11;
        commit_valid = 1'b1; commit_id = 2'd1;
        @(posedge clk);
        #1 issue_valid = 1'b0; commit_valid = 1'b0;
        mq.push_back('{id: 2'd1, rd: 5'd11, op: 1, a: rs1, b: rs2,
                       committed: 1'b0, killed: 1'b0});
        idle_watch(10, seen);
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL same_cycle_commit: result seen %b want 0", seen);
        end
        do_commit(2'd1, 1'b0);
        build_expected();
        collect(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if ({obs_q[i].got, obs_q[i].id, obs_q[i].data} !==
                {1'b1, exp_q[i].id, exp_q[i].data}) begin
                miscompares++;
                $display("FAIL late_commit_res: got v%b id%0d data %h want id%0d data %h",
                         obs_q[i].got, obs_q[i].id, obs_q[i].data,
                         exp_q[i].id, exp_q[i].data);
            end
        end
        do_issue(mk_instr(3'b011, 5'd12, 7'h7B, 7'd0), 2'd0,
                 $urandom, $urandom, 2'b00, acc, wb);
        vectors++;
        if ({acc, wb} !== 2'b10) begin
            miscompares++;
            $display("FAIL nop_accept: acc/wb %b want 10", {acc, wb});
        end
        do_commit(2'd0, 1'b0);
        idle_watch(8, seen);
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL nop_noresult: result seen %b want 0", seen);
        end
        mq.delete();
    endtask

    task automatic test_full();
        logic acc, wb;
        logic [31:0] exp0;
        logic [38:0] snap;
        int cyc = 0;
        for (int i = 0; i < DEPTH; i++)
            do_issue(mk_instr(3'($urandom_range(0, 2)), 5'($urandom), 7'h7B, 7'd0),
                     2'(i), $urandom, $urandom, 2'b11, acc, wb);
        vectors++;
        if (issue_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready: ready %b want 0", issue_ready);
        end
        exp0 = ref_alu(mq[0].op, mq[0].a, mq[0].b);
        do_commit(2'd0, 1'b0);
        while (cyc < 20 && !result_valid) begin
            @(posedge clk); #1;
            cyc++;
        end
        snap = {result_id, result_rd, result_data};
        vectors++;
        if ({result_valid, snap} !== {1'b1, 2'd0, mq[0].rd, exp0}) begin
            miscompares++;
            $display("FAIL full_res0: v%b id%0d rd%0d data %h want id0 rd%0d data %h",
                     result_valid, result_id, result_rd, result_data, mq[0].rd, exp0);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({result_valid, issue_ready, result_id, result_rd, result_data} !==
                {2'b10, snap}) begin
                miscompares++;
                $display("FAIL hold%0d: v%b rdy%b id%0d rd%0d data %h want held %h",
                         i, result_valid, issue_ready, result_id, result_rd,
                         result_data, snap);
            end
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
        vectors++;
        if (issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_free: ready %b want 1", issue_ready);
        end
        void'(mq.pop_front());
        for (int i = 1; i < DEPTH; i++) do_commit(2'(i), 1'b0);
        build_expected();
        collect(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if ({obs_q[i].got, obs_q[i].id, obs_q[i].rd, obs_q[i].data} !==
                {1'b1, exp_q[i].id, exp_q[i].rd, exp_q[i].data}) begin
                miscompares++;
                $display("FAIL full_res%0d: got v%b id%0d rd%0d data %h, want id%0d rd%0d data %h",
                         i + 1, obs_q[i].got, obs_q[i].id, obs_q[i].rd, obs_q[i].data,
                         exp_q[i].id, exp_q[i].rd, exp_q[i].data);
            end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_random();
        logic acc, wb;
        bit racc, rwb;
        int op, k, kind, j;
        logic [31:0] ins;
        logic [1:0] rsv, tmp;
        logic [1:0] ids [4];
        logic [1:0] cids[$];
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) ids[i] = 2'(i);
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = ids[i]; ids[i] = ids[j]; ids[j] = tmp;
            end
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) begin
                kind = $urandom_range(0, 9);
                if (kind == 0)
                    ins = mk_instr(3'($urandom), 5'($urandom), 7'($urandom), 7'd0);
                else if (kind == 1)
                    ins = mk_instr(3'($urandom_range(4, 7)), 5'($urandom), 7'h7B, 7'd0);
                else
                    ins = mk_instr(3'($urandom_range(0, 3)), 5'($urandom), 7'h7B, 7'd0);
                rsv = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
                do_issue(ins, ids[i], $urandom, $urandom, rsv, acc, wb);
                ref_decode(ins, rsv, racc, rwb, op);
                vectors++;
                if ({acc, wb} !== {racc, rwb}) begin
                    miscompares++;
                    $display("FAIL rnd_issue r%0d i%0d: acc/wb %b want %b ins %h",
                             r, i, {acc, wb}, {racc, rwb}, ins);
                end
            end
            cids.delete();
            foreach (mq[i]) cids.push_back(mq[i].id);
            for (int i = cids.size() - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = cids[i]; cids[i] = cids[j]; cids[j] = tmp;
            end
            foreach (cids[i]) do_commit(cids[i], $urandom_range(0, 4) == 0);
            build_expected();
            collect(exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if ({obs_q[i].got, obs_q[i].id, obs_q[i].rd, obs_q[i].we, obs_q[i].data} !==
                    {1'b1, exp_q[i].id, exp_q[i].rd, exp_q[i].we, exp_q[i].data}) begin
                    miscompares++;
                    $display("FAIL rnd_res r%0d i%0d: got v%b id%0d rd%0d we%b data %h, want id%0d rd%0d data %h",
                             r, i, obs_q[i].got, obs_q[i].id, obs_q[i].rd, obs_q[i].we,
                             obs_q[i].data, exp_q[i].id, exp_q[i].rd, exp_q[i].data);
                end
            end
            repeat (8) @(posedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic acc, wb;
        bit seen;
        for (int i = 0; i < 3; i++)
            do_issue(mk_instr(3'b000, 5'($urandom), 7'h7B, 7'd0), 2'(i),
                     $urandom, $urandom, 2'b11, acc, wb);
        do_commit(2'd0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({issue_ready, result_valid, result_data} !== {2'b10, 32'd0}) begin
            miscompares++;
            $display("FAIL mid_reset: ready %b valid %b data %h want 1 0 0",
                     issue_ready, result_valid, result_data);
        end
        mq.delete();
        @(negedge clk) rst_n = 1'b1;
        do_commit(2'd0, 1'b0);
        idle_watch(6, seen);
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL mid_reset_flush: stale result seen %b want 0", seen);
        end
        mq.delete();
        do_issue(mk_instr(3'b000, 5'd3, 7'h7B, 7'd0), 2'd3,
                 32'hFFFF_FFFF, 32'd1, 2'b11, acc, wb);
        do_commit(2'd3, 1'b0);
        build_expected();
        collect(exp_q.size());
        vectors++;
        if (exp_q.size() != 1 || obs_q[0].got !== 1'b1 ||
            obs_q[0].data !== 32'd0 || obs_q[0].data !== exp_q[0].data) begin
            miscompares++;
            $display("FAIL wrap_add: got v%b data %h want 00000000",
                     obs_q[0].got, obs_q[0].data);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_reject();
        test_order();
        test_kill();
        test_full();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/cvxif_copro_responder.md
Name: cvxif_copro_responder

Overview:
- Coprocessor-side responder for the CV-X-IF interface that the core issues to when its CVX-IF option is enabled.
- Accepts or rejects offloaded custom-3 instructions, buffers accepted ones in an in-order queue, and waits for the core's commit/kill.
- Executes committed instructions with a fixed latency and returns results through a valid/ready result handshake.
- Serves as the reference coprocessor for core-side X-interface verification.

Parameters:
- XLEN, 32, operand/result width; matches core XLEN.
- ID_WIDTH, 2, instruction ID width; log2 of the core's scoreboard entries (4).
- DEPTH, 4, queue entries; power of two, ≥2.
- EXEC_LAT, 2, execution cycles after a committed entry reaches head; ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- x_issue_valid_i  in  1  issue request valid
- x_issue_ready_o  out  1  responder can take request
- x_issue_instr_i  in  32  instruction word
- x_issue_id_i  in  ID_WIDTH  instruction ID
- x_issue_rs1_i  in  XLEN  operand 1
- x_issue_rs2_i  in  XLEN  operand 2
- x_issue_rs_valid_i  in  2  operand valid bits
- x_issue_accept_o  out  1  instruction accepted (valid with handshake)
- x_issue_writeback_o  out  1  accepted instruction writes rd
- x_commit_valid_i  in  1  commit message valid
- x_commit_id_i  in  ID_WIDTH  committed ID
- x_commit_kill_i  in  1  discard the instruction
- x_result_valid_o  out  1  result valid
- x_result_ready_i  in  1  core takes result
- x_result_id_o  out  ID_WIDTH  result ID
- x_result_data_o  out  XLEN  result value
- x_result_rd_o  out  5  destination register
- x_result_we_o  out  1  register write enable

Behaviour:
- Reset (async, rst_ni low): queue empty, all entry flags clear, FSM in IDLE, counter 0. Outputs: x_issue_ready_o=1, x_result_valid_o=0, result id/data/rd/we=0.
- Decode (combinational):
  - Opcode 7'b1111011 and funct7=0.
  - funct3 000 ADD rs1+rs2 (mod 2^XLEN); 001 XOR; 010 SLL rs1<<rs2[4:0]; 011 NOP (accept, writeback=0).
  - Anything else is rejected.
- Issue handshake:
  - x_issue_ready_o = !full. No bypass when full, even if the head dequeues the same cycle.
  - accept/writeback are meaningful only when valid&&ready, and are combinational in that cycle.
  - Accept requires both rs_valid bits set for ADD/XOR/SLL.
  - Accepted entries are enqueued with id, rd, op, rs1, rs2, committed=0, killed=0.
  - Rejected instructions are not enqueued and produce no result.
- Commit:
  - On x_commit_valid_i, every valid entry whose id matches sets committed; kill additionally sets killed.
  - A commit for an absent ID is ignored.
  - A commit arriving in the same cycle as issue of that ID does not apply to the new entry.
- FSM:
  - IDLE: if head valid and committed:
    - killed or NOP → dequeue, stay IDLE (1 cycle per entry).
    - otherwise → EXEC, counter=EXEC_LAT-1.
  - EXEC: decrement the counter. At 0, register the result, assert x_result_valid_o, go to RESP. Latency from head-committed to result_valid is EXEC_LAT+1 cycles.
  - RESP: hold all result outputs stable until x_result_ready_i. On handshake, dequeue the head, drop valid, go to IDLE.
  - Back-to-back results are separated by at least one IDLE cycle.
- Results:
  - Returned strictly in issue order.
  - x_result_we_o = 1 and x_result_rd_o = rd for all writeback ops.
- Simultaneous events: enqueue and dequeue in the same cycle are allowed when not full; the count is unchanged.
- Wrap: read/write pointers are log2(DEPTH)+1 bits. Full when the MSBs differ and the rest are equal.
- Duplicate in-flight IDs are a protocol violation (assertion). Behaviour is undefined.

Decomposition:
- Shared package cvxif_copro_pkg:
  - opcode/funct constants
  - op enum (ADD, XOR, SLL, NOP)
  - queue entry struct
  - FSM state enum
- Sub-module cvxif_copro_queue: DEPTH-entry circular buffer with by-ID commit/kill marking and head pop.
- Top holds the decoder, FSM and ALU.

Test Plan:
- Issue ADD (funct3 000, rd=5, id=1), rs1=0x0000_0003, rs2=0x0000_0004 → accept=1, writeback=1. Commit id1 → result_valid EXEC_LAT+1 cycles later, data=0x7, rd=5, id=1.
- Issue with opcode 0x33 → accept=0, no queue entry, no result ever.
- Issue XOR id0, then SLL id1 (rs1=1, rs2=0x24). Commit id1 before id0 → no result until id0 commits. Results in order: id0 first, then id1 with data=0x10.
- Issue ADD id2, commit with kill → entry dropped in 1 cycle, result_valid never asserted, next entry proceeds.
- Fill 4 entries uncommitted → x_issue_ready_o=0. Commit id0 and hold x_result_ready_i=0 for 5 cycles → outputs stable. On ready, entry frees and x_issue_ready_o=1 the next cycle.
- Assert rst_ni low during EXEC with 3 entries queued → immediately ready=1, result_valid=0. Post-reset ADD 0xFFFF_FFFF+1 → data=0.
